// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for NUM_DIGITS common-anode digits sharing one
// seven_seg decoder; double-buffered frames applied only at frame boundaries.
module seg_scan_ctrl #(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned DIV        = 1000,
    parameter int unsigned BLANK_CYC  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic                      load,
    input  logic [3*NUM_DIGITS-1:0]   digits_in,
    output logic [2:0]                dec_in,
    output logic [NUM_DIGITS-1:0]     an,
    output logic                      frame_done,
    output logic                      load_ack
);

    localparam int unsigned CNT_MAX = (DIV > BLANK_CYC) ? DIV : BLANK_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned IW      = $clog2(NUM_DIGITS);
    localparam bit          HAS_BLANK = (BLANK_CYC != 0);

    localparam logic [CW-1:0]         DIV_LAST   = CW'(DIV - 1);
    localparam logic [CW-1:0]         BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYC - 1 : 0);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] DIGIT0     = NUM_DIGITS'(1);

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        SHOW
    } state_t;

    state_t                       state, state_nxt;
    logic [IW-1:0]                idx, idx_nxt;
    logic [CW-1:0]                cnt, cnt_nxt;
    logic                         boundary;

    logic [NUM_DIGITS-1:0][2:0]   active;
    logic [NUM_DIGITS-1:0][2:0]   shadow;
    logic                         pending;
    logic                         frame_evt;
    logic                         ack_evt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt;
        boundary  = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = HAS_BLANK ? BLANK : SHOW;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end
            end
            BLANK: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt == BLANK_LAST) begin
                    state_nxt = SHOW;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            SHOW: begin
                if (!enable) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                    cnt_nxt   = '0;
                end else if (cnt == DIV_LAST) begin
                    state_nxt = HAS_BLANK ? BLANK : SHOW;
                    cnt_nxt   = '0;
                    if (idx == IDX_LAST) begin
                        idx_nxt  = '0;
                        boundary = 1'b1;
                    end else begin
                        idx_nxt = idx + 1'b1;
                    end
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
                cnt_nxt   = '0;
            end
        endcase
    end

    // A load on the boundary cycle wins over any older shadow contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active    <= '0;
            shadow    <= '0;
            pending   <= 1'b0;
            frame_evt <= 1'b0;
            ack_evt   <= 1'b0;
        end else begin
            frame_evt <= boundary;
            ack_evt   <= 1'b0;
            if (state == IDLE) begin
                if (load) begin
                    active  <= digits_in;
                    ack_evt <= 1'b1;
                end
            end else if (boundary) begin
                if (load) begin
                    active  <= digits_in;
                    pending <= 1'b0;
                    ack_evt <= 1'b1;
                end else if (pending) begin
                    active  <= shadow;
                    pending <= 1'b0;
                    ack_evt <= 1'b1;
                end
            end else if (load) begin
                shadow  <= digits_in;
                pending <= 1'b1;
            end
        end
    end

    // Outputs trail the state by one cycle so events line up with new dec_in data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an         <= '1;
            dec_in     <= '0;
            frame_done <= 1'b0;
            load_ack   <= 1'b0;
        end else begin
            an         <= '1;
            dec_in     <= '0;
            frame_done <= frame_evt;
            load_ack   <= ack_evt;
            case (state)
                BLANK: dec_in <= active[idx];
                SHOW: begin
                    dec_in <= active[idx];
                    an     <= ~(DIGIT0 << idx);
                end
                default: ;
            endcase
        end
    end

endmodule
